// File: rtl/alu_pkg.sv
// Shared ALU definitions for the mult/div sequencer.
// Holds the ALU control codes, sequencer state encoding and divide-by-zero fill.
package alu_pkg;

    localparam logic [3:0] ALU_MULT = 4'b0101;
    localparam logic [3:0] ALU_DIV  = 4'b1011;

    // LO is filled with this bit on divide by zero (all ones).
    localparam logic DIV0_LO_BIT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of unsigned shift-add multiply or restoring divide.
// Ports: op_div selects divide; p/q are the accumulator halves; opnd is multiplicand/divisor.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             op_div,
    input  logic [WIDTH:0]   p,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH:0]   p_nxt,
    output logic [WIDTH-1:0] q_nxt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] p_add;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum    = p + {1'b0, opnd};
        p_add  = q[0] ? sum : p;
        rem_sh = {p[WIDTH-1:0], q[WIDTH-1]};
        diff   = rem_sh - {1'b0, opnd};
        p_nxt  = p;
        q_nxt  = q;
        unique case (1'b1)
            // mult: {p,q} shifts right as one 2W+1 bit register
            !op_div: begin
                p_nxt = {1'b0, p_add[WIDTH:1]};
                q_nxt = {p_add[0], q[WIDTH-1:1]};
            end
            // div: shift dividend msb into rem, restore on underflow
            op_div: begin
                if (rem_sh >= {1'b0, opnd}) begin
                    p_nxt = diff;
                    q_nxt = {q[WIDTH-2:0], 1'b1};
                end else begin
                    p_nxt = rem_sh;
                    q_nxt = {q[WIDTH-2:0], 1'b0};
                end
            end
            default: begin
                p_nxt = p;
                q_nxt = q;
            end
        endcase
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed mult/div sequencer writing HI/LO beside the EX-stage ALU.
// Ports: start/alu_ctrl/op_a/op_b launch; hilo_read for stall; busy/stall/done/hi/lo out.
module muldiv_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hilo_read,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_t            state;
    logic [CW-1:0]     count;
    logic              op_div;
    logic              dz;
    logic              neg_res;
    logic              neg_rem;
    logic [WIDTH:0]    p;
    logic [WIDTH-1:0]  q;
    logic [WIDTH-1:0]  opnd;

    logic [WIDTH:0]    p_nxt;
    logic [WIDTH-1:0]  q_nxt;
    logic              is_mult;
    logic              is_div;
    logic              accept;
    logic              b_zero;
    logic [WIDTH-1:0]  mag_a;
    logic [WIDTH-1:0]  mag_b;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]  quo_fix;
    logic [WIDTH-1:0]  rem_fix;

    assign is_mult = (alu_ctrl == ALU_MULT);
    assign is_div  = (alu_ctrl == ALU_DIV);
    assign busy    = (state != IDLE);
    assign stall   = busy & (start | hilo_read);
    assign accept  = start & ~busy & (is_mult | is_div);
    assign b_zero  = (op_b == '0);

    // Magnitudes are unsigned, so the most negative value maps to 2^(W-1).
    assign mag_a = op_a[WIDTH-1] ? -op_a : op_a;
    assign mag_b = op_b[WIDTH-1] ? -op_b : op_b;

    always_comb begin
        prod     = {p[WIDTH-1:0], q};
        prod_fix = neg_res ? -prod : prod;
        quo_fix  = neg_res ? -q : q;
        rem_fix  = neg_rem ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    end

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op_div (op_div),
        .p      (p),
        .q      (q),
        .opnd   (opnd),
        .p_nxt  (p_nxt),
        .q_nxt  (q_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            op_div  <= 1'b0;
            dz      <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            p       <= '0;
            q       <= '0;
            opnd    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_div  <= is_div;
                        neg_res <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        neg_rem <= op_a[WIDTH-1];
                        count   <= '0;
                        dz      <= is_div & b_zero;
                        if (is_div && b_zero) begin
                            // raw dividend goes straight to HI
                            p     <= {1'b0, op_a};
                            q     <= {WIDTH{DIV0_LO_BIT}};
                            state <= FIX;
                        end else begin
                            p     <= '0;
                            q     <= is_div ? mag_a : mag_b;
                            opnd  <= is_div ? mag_b : mag_a;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    p     <= p_nxt;
                    q     <= q_nxt;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    if (dz) begin
                        hi <= p[WIDTH-1:0];
                        lo <= q;
                    end else if (op_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
